// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed two-digit active-low seven-segment bus and rebuilds
// the displayed decimal value (0..99), pulsing Valid once per completed frame.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] HexSeg,
  input  logic [1:0] DigEn,
  output logic [7:0] Value,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic       Valid,
  output logic       Err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {SCAN, EMIT} state_t;

  state_t     state, state_next;
  logic [6:0] seg_q;
  logic [1:0] en_q;
  logic [8:0] prev_q;
  logic [7:0] cnt, cnt_next;
  logic       same, capture;
  logic [3:0] dig;
  logic       bad;
  logic [3:0] ones_d, tens_d;
  logic       bad_ones, bad_tens, cap_ones, cap_tens;
  logic [7:0] value_calc;

  // Glyph table for active-low g..a patterns; unknown glyphs read as 0 and flag bad.
  always_comb begin
    dig = 4'd0;
    bad = 1'b0;
    case (seg_q)
      7'h40: dig = 4'd0;
      7'h79: dig = 4'd1;
      7'h24: dig = 4'd2;
      7'h30: dig = 4'd3;
      7'h19: dig = 4'd4;
      7'h12: dig = 4'd5;
      7'h02: dig = 4'd6;
      7'h78: dig = 4'd7;
      7'h00: dig = 4'd8;
      7'h10: dig = 4'd9;
      default: bad = 1'b1;
    endcase
  end

  // A changed sample always restarts the count at 1, so with STABLE=1 every
  // change is a capture; a held pattern saturates and never recaptures.
  always_comb begin
    same     = ({en_q, seg_q} == prev_q);
    cnt_next = 8'd1;
    if (same) cnt_next = (cnt >= STABLE) ? cnt : cnt + 8'd1;
    capture  = (cnt_next == STABLE) && (!same || cnt != STABLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 7'h7F;
      en_q   <= 2'b11;
      prev_q <= 9'h1FF;
      cnt    <= 8'd0;
    end else begin
      seg_q  <= HexSeg;
      en_q   <= DigEn;
      prev_q <= {en_q, seg_q};
      cnt    <= cnt_next;
    end
  end

  // Clearing in EMIT comes first so a capture in the same cycle starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_d   <= 4'd0;
      tens_d   <= 4'd0;
      bad_ones <= 1'b0;
      bad_tens <= 1'b0;
      cap_ones <= 1'b0;
      cap_tens <= 1'b0;
    end else begin
      if (state == EMIT) begin
        cap_ones <= 1'b0;
        cap_tens <= 1'b0;
        bad_ones <= 1'b0;
        bad_tens <= 1'b0;
      end
      if (capture && en_q == 2'b10) begin
        ones_d   <= dig;
        bad_ones <= bad;
        cap_ones <= 1'b1;
      end
      if (capture && en_q == 2'b01) begin
        tens_d   <= dig;
        bad_tens <= bad;
        cap_tens <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SCAN:    if (cap_ones && cap_tens) state_next = EMIT;
      EMIT:    state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_next;
  end

  assign value_calc = {1'b0, tens_d, 3'b000} + {3'b000, tens_d, 1'b0} + {4'd0, ones_d};

  // Outputs load on entry to EMIT so Valid is high exactly for the EMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Value <= 8'd0;
      Ones  <= 4'd0;
      Tens  <= 4'd0;
      Valid <= 1'b0;
      Err   <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (state == SCAN && state_next == EMIT) begin
        Value <= value_calc;
        Ones  <= ones_d;
        Tens  <= tens_d;
        Err   <= bad_ones | bad_tens;
        Valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads back a multiplexed two-digit, active-low seven-segment display bus (segment lines plus digit enables) and reconstructs the displayed decimal value 0..99 as 8-bit binary.
- It is the reader for the decimal-to-seven-segment display path. It is used for self-checking display output on hardware and in the lab bench.
- Each digit is accepted only after its pattern has been stable for a programmable number of clocks. Each completed frame produces a one-cycle valid pulse.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical registered samples (1..255) that accept a digit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- HexSeg  input  7  segment lines, active-low. Bit0=a, bit1=b, …, bit6=g.
- DigEn  input  2  digit enables, active-low. DigEn[0]=ones digit, DigEn[1]=tens digit.
- Value  output  8  decoded value, tens*10+ones, range 0..99.
- Ones  output  4  last frame ones digit, BCD.
- Tens  output  4  last frame tens digit, BCD.
- Valid  output  1  one-cycle pulse when Value/Ones/Tens/Err update.
- Err  output  1  set with Valid if either digit pattern was not a legal 0..9 glyph.

Behaviour:
- Reset (async, rst_n=0): Value=0, Ones=0, Tens=0, Valid=0, Err=0. Sample registers=7'h7F/2'b11, stability counter=0, captured flags=0, FSM=SCAN.
- Input stage: HexSeg and DigEn are registered once into seg_q and en_q every clock. All decisions use the registered values.
- Stability counter:
  - If {en_q,seg_q} equals its value on the previous clock, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt is set to 1.
  - A capture event happens on the edge where cnt transitions to STABLE_CYCLES, exactly once per stable period.
  - A pattern held longer does not recapture.
  - With STABLE_CYCLES=1, every changed sample is a capture event.
- Digit enable validity:
  - en_q=2'b10 selects ones; en_q=2'b01 selects tens.
  - en_q=2'b11 (blank) and 2'b00 (both on) produce no capture and leave captured flags unchanged.
- Glyph decode (seg_q, active-low g..a):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any other pattern decodes to digit 0 and sets that slot's bad flag.
- Capture: on a capture event, write the decoded digit and bad flag into the selected slot and set that slot's captured flag. Recapturing a slot before the frame completes overwrites it (last wins).
- FSM:
  - SCAN: collect digits. When both captured flags are set after a capture edge, go to EMIT.
  - EMIT (exactly one cycle):
    - Valid=1.
    - Ones/Tens take the slot digits.
    - Value=Tens*10+Ones, computed from the slot digits in 8-bit unsigned (max 99, no overflow).
    - Err = bad_ones | bad_tens.
    - Captured and bad flags are cleared.
    - Return to SCAN.
- Output timing:
  - Valid asserts on the clock after the completing capture edge and deasserts the following clock.
  - Value/Ones/Tens/Err hold between pulses.
  - Err is only meaningful while Valid=1, but is held like the others.
- Simultaneous events: a capture event in the EMIT cycle is recorded into the freshly cleared slots. Clearing happens first, then the new capture is applied, so it counts toward the next frame.
- Reset mid-frame: partial captures are discarded. The first Valid after reset needs both digits captured anew.
- Digit order is free: tens-then-ones and ones-then-tens both complete a frame.

Test Plan (STABLE_CYCLES=4):
- Reset held 3 clocks, inputs idle (HexSeg=7'h7F, DigEn=2'b11) -> all outputs 0, no Valid for 50 clocks.
- Drive DigEn=2'b10/HexSeg=7'h12 for 6 clocks, then DigEn=2'b01/HexSeg=7'h30 for 6 clocks -> single Valid pulse, Value=8'd35, Ones=5, Tens=3, Err=0. Valid occurs 4 registered-stable clocks plus 1 clock after the tens pattern starts reaching seg_q.
- Ones glyph 7'h12 held only 3 clocks, then tens 7'h24 held 6 clocks -> no Valid (ones never accepted). Then ones 7'h10 held 5 clocks -> Value=8'd29.
- Tens 7'h7F (blank glyph) with DigEn=2'b01, plus ones 7'h40 -> Valid with Err=1, Tens=0, Ones=0, Value=0.
- Continuous multiplex alternating 5 clocks per digit showing "99" (7'h10 both) -> a Valid every second digit period, Value=8'd99. Then DigEn=2'b00 for 20 clocks -> no capture and outputs held at 99.
- Reset asserted asynchronously mid-clock after only the ones digit is captured -> outputs clear immediately. After release, a tens-only capture gives no Valid until a ones capture follows.
